// File: rtl/expendedora_pkg.sv
// Shared types and constants for the vending-machine (expendedora) datapath:
// coin denomination indexing, default coin values and the change-payout FSM
// state encoding. The default coin values are also used by the coin-intake block.
package expendedora_pkg;

  localparam int unsigned NUM_DENOM = 3;
  localparam int unsigned AMT_W     = 8;
  localparam int unsigned TMR_W     = 16;

  localparam int unsigned DEF_VAL0 = 1;
  localparam int unsigned DEF_VAL1 = 2;
  localparam int unsigned DEF_VAL2 = 5;

  typedef logic [1:0] coin_idx_t;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    EJECT,
    WAIT,
    GAP,
    FAULT
  } cambio_state_t;

  // One-hot solenoid pattern for a denomination index.
  function automatic logic [NUM_DENOM-1:0] coin_onehot(input coin_idx_t d);
    return NUM_DENOM'(1) << d;
  endfunction

endpackage

// File: rtl/cambio_timer.sv
// Loadable down-counter with a zero flag. Used by the payout engine for the
// solenoid pulse, inter-coin gap and coin-sensor timeout intervals.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   load      : load load_val this cycle (takes priority over counting)
//   load_val  : value to load; zero_c rises load_val cycles after the load
//   zero_c    : combinational decode of count == 0
module cambio_timer
  import expendedora_pkg::*;
#(
  parameter int unsigned W = TMR_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero_c
);

  logic [W-1:0] count_q;

  // Count down to zero and hold there until reloaded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (count_q != '0) begin
      count_q <= count_q - W'(1);
    end
  end

  assign zero_c = (count_q == '0);

endmodule

// File: rtl/cambio_dispensador.sv
// Change-payout engine. Accepts a change amount from the vending controller
// and pays it out greedily (largest coin first) through three hopper eject
// solenoids, confirming each coin on the exit sensor. Reports done, or a
// sticky fault on an empty hopper set or a sensor timeout.
// Build option: define CAMBIO_RETRY_EN to re-pulse a coin once after its
// first sensor timeout before faulting.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   req_valid    : change request valid; req_ready high only in IDLE
//   req_amount   : change owed in base units, sampled on handshake
//   empty        : per-denomination hopper empty flags
//   coin_sensed  : single-cycle exit-sensor pulse
//   eject        : one-hot solenoid drive, index = denomination
//   busy         : high in every state except IDLE and FAULT
//   done         : one-cycle pulse on a completed payout
//   fault        : sticky fault, cleared by the next accepted request
//   remaining    : units still owed
module cambio_dispensador
  import expendedora_pkg::*;
#(
  parameter int unsigned VAL0           = DEF_VAL0,
  parameter int unsigned VAL1           = DEF_VAL1,
  parameter int unsigned VAL2           = DEF_VAL2,
  parameter int unsigned PULSE_CYCLES   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned GAP_CYCLES     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [AMT_W-1:0]     req_amount,
  input  logic [NUM_DENOM-1:0] empty,
  input  logic                 coin_sensed,
  output logic [NUM_DENOM-1:0] eject,
  output logic                 busy,
  output logic                 done,
  output logic                 fault,
  output logic [AMT_W-1:0]     remaining
);

  localparam logic [AMT_W-1:0] V0 = AMT_W'(VAL0);
  localparam logic [AMT_W-1:0] V1 = AMT_W'(VAL1);
  localparam logic [AMT_W-1:0] V2 = AMT_W'(VAL2);
  // Timers reach zero load_val cycles after loading, so load N-1 for N cycles.
  localparam logic [TMR_W-1:0] PULSE_LD = TMR_W'(PULSE_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMO_LD   = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_LD   = TMR_W'(GAP_CYCLES - 1);

  cambio_state_t          state_q, state_d;
  coin_idx_t              d_q, d_d;
  logic                   sensed_q, sensed_d;
  logic [NUM_DENOM-1:0]   eject_d;
  logic                   busy_d, done_d, fault_d, req_ready_d;
  logic [AMT_W-1:0]       remaining_d;
  logic                   pt_load, to_load, pt_zero, to_zero;
  logic [TMR_W-1:0]       pt_val;
  logic                   sel_ok, go_gap, tmo_hit, sensed_now;
  coin_idx_t              sel_idx;
  logic [AMT_W-1:0]       coin_val;
`ifdef CAMBIO_RETRY_EN
  logic                   retry_q, retry_d;
`endif

  // Pulse and gap share one timer; the timeout runs concurrently with the pulse.
  cambio_timer #(.W(TMR_W)) u_pulse_tmr (
    .clk      (clk),
    .rst      (rst),
    .load     (pt_load),
    .load_val (pt_val),
    .zero_c   (pt_zero)
  );

  cambio_timer #(.W(TMR_W)) u_tmo_tmr (
    .clk      (clk),
    .rst      (rst),
    .load     (to_load),
    .load_val (TMO_LD),
    .zero_c   (to_zero)
  );

  // Greedy choice: largest non-empty denomination that fits.
  always_comb begin
    sel_ok  = 1'b1;
    sel_idx = 2'd2;
    if (!empty[2] && remaining >= V2) begin
      sel_idx = 2'd2;
    end else if (!empty[1] && remaining >= V1) begin
      sel_idx = 2'd1;
    end else if (!empty[0] && remaining >= V0) begin
      sel_idx = 2'd0;
    end else begin
      sel_ok = 1'b0;
    end
  end

  always_comb begin
    case (d_q)
      2'd0:    coin_val = V0;
      2'd1:    coin_val = V1;
      default: coin_val = V2;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    d_d         = d_q;
    sensed_d    = sensed_q;
    remaining_d = remaining;
    eject_d     = '0;
    done_d      = 1'b0;
    fault_d     = fault;
    pt_load     = 1'b0;
    pt_val      = PULSE_LD;
    to_load     = 1'b0;
    go_gap      = 1'b0;
    tmo_hit     = 1'b0;
    sensed_now  = sensed_q | coin_sensed;
`ifdef CAMBIO_RETRY_EN
    retry_d     = retry_q;
`endif

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          remaining_d = req_amount;
          fault_d     = 1'b0;
          state_d     = SELECT;
`ifdef CAMBIO_RETRY_EN
          retry_d     = 1'b0;
`endif
        end
      end
      SELECT: begin
        if (remaining == '0) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (sel_ok) begin
          d_d      = sel_idx;
          eject_d  = coin_onehot(sel_idx);
          pt_load  = 1'b1;
          to_load  = 1'b1;
          sensed_d = 1'b0;
          state_d  = EJECT;
        end else begin
          state_d = FAULT;
        end
      end
      EJECT: begin
        // Pulse always runs to full width; the sensor result is acted on after.
        sensed_d = sensed_now;
        eject_d  = coin_onehot(d_q);
        if (pt_zero) begin
          eject_d = '0;
          if (sensed_now) begin
            go_gap = 1'b1;
          end else if (to_zero) begin
            tmo_hit = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (coin_sensed) begin
          go_gap = 1'b1;
        end else if (to_zero) begin
          tmo_hit = 1'b1;
        end
      end
      GAP: begin
        if (pt_zero) begin
          state_d = SELECT;
        end
      end
      FAULT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (go_gap) begin
      remaining_d = remaining - coin_val;
      pt_load     = 1'b1;
      pt_val      = GAP_LD;
      state_d     = GAP;
`ifdef CAMBIO_RETRY_EN
      retry_d     = 1'b0;
`endif
    end

    if (tmo_hit) begin
`ifdef CAMBIO_RETRY_EN
      if (!retry_q) begin
        retry_d  = 1'b1;
        eject_d  = coin_onehot(d_q);
        pt_load  = 1'b1;
        pt_val   = PULSE_LD;
        to_load  = 1'b1;
        sensed_d = 1'b0;
        state_d  = EJECT;
      end else begin
        state_d = FAULT;
      end
`else
      state_d = FAULT;
`endif
    end

    busy_d      = (state_d == SELECT) || (state_d == EJECT) ||
                  (state_d == WAIT)   || (state_d == GAP);
    req_ready_d = (state_d == IDLE);
    if (state_d == FAULT) begin
      fault_d = 1'b1;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      d_q       <= 2'd0;
      sensed_q  <= 1'b0;
      eject     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fault     <= 1'b0;
      remaining <= '0;
      req_ready <= 1'b1;
    end else begin
      state_q   <= state_d;
      d_q       <= d_d;
      sensed_q  <= sensed_d;
      eject     <= eject_d;
      busy      <= busy_d;
      done      <= done_d;
      fault     <= fault_d;
      remaining <= remaining_d;
      req_ready <= req_ready_d;
    end
  end

`ifdef CAMBIO_RETRY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retry_q <= 1'b0;
    end else begin
      retry_q <= retry_d;
    end
  end
`endif

endmodule

// File: tb/tb_cambio_dispensador.sv
// Directed bench for cambio_dispensador: greedy payout sequences, zero
// request, empty-hopper fault, sensor timeout and asynchronous reset.
module tb_cambio_dispensador;

  logic       clk = 1'b0;
  logic       rst, req_valid, req_ready, coin_sensed, busy, done, fault;
  logic [7:0] req_amount, remaining;
  logic [2:0] empty, eject;

  int n_checks = 0;
  int n_fail   = 0;
  int ej_code, ej_n, rem_code, n_done, ej_cycles;
  bit sensor_en;

  always #5 clk = ~clk;

  cambio_dispensador #(
    .VAL0           (1),
    .VAL1           (2),
    .VAL2           (5),
    .PULSE_CYCLES   (4),
    .TIMEOUT_CYCLES (20),
    .GAP_CYCLES     (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_amount  (req_amount),
    .empty       (empty),
    .coin_sensed (coin_sensed),
    .eject       (eject),
    .busy        (busy),
    .done        (done),
    .fault       (fault),
    .remaining   (remaining)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Records eject rises (hex digits of the index), remaining changes, done pulses.
  initial begin
    logic [2:0] pe;
    logic [7:0] pr;
    pe = '0;
    pr = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pe = '0;
        pr = '0;
      end else begin
        if (eject != 0 && pe == 0) begin
          ej_code = ej_code * 16 + (eject[2] ? 2 : (eject[1] ? 1 : 0));
          ej_n++;
        end
        if (eject != 0) ej_cycles++;
        if (remaining != pr) rem_code = rem_code * 16 + int'(remaining);
        if (done) n_done++;
        pe = eject;
        pr = remaining;
      end
    end
  end

  // Exit sensor: one pulse, sampled on the 3rd edge after each eject rise.
  initial begin
    logic [2:0] last;
    last = '0;
    coin_sensed = 1'b0;
    forever begin
      @(negedge clk);
      if (sensor_en && eject != 0 && last == 0) begin
        repeat (2) @(negedge clk);
        coin_sensed = 1'b1;
        @(negedge clk);
        coin_sensed = 1'b0;
      end
      last = eject;
    end
  end

  task automatic apply_reset();
    rst = 1'b1;
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    ej_code = 0; ej_n = 0; rem_code = 0; n_done = 0; ej_cycles = 0;
  endtask

  // Returns at the negedge just after the handshake edge.
  task automatic start_req(input logic [7:0] amt);
    int i;
    @(negedge clk);
    req_amount = amt;
    req_valid  = 1'b1;
    i = 0;
    while (!req_ready && i < 50) begin
      @(negedge clk);
      i++;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // k = edges after the handshake edge until done or fault is seen.
  task automatic wait_end(input string tag, input int budget, output int k);
    k = 0;
    while (!(done || fault) && k < budget) begin
      @(negedge clk);
      k++;
    end
    check_eq(tag, 32'(done || fault), 32'd1);
  endtask

  initial begin
    int k;
    rst = 1'b1; req_valid = 1'b0; req_amount = '0; empty = '0; sensor_en = 1'b0;
    ej_code = 0; ej_n = 0; rem_code = 0; n_done = 0; ej_cycles = 0;
    apply_reset();
    check_eq("rst_eject", 32'(eject), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_fault", 32'(fault), 32'd0);
    check_eq("rst_remaining", 32'(remaining), 32'd0);
    check_eq("rst_req_ready", 32'(req_ready), 32'd1);

    // 8 units: 5,2,1
    sensor_en = 1'b1;
    start_req(8'd8);
    wait_end("a8_end", 200, k);
    @(negedge clk);
    check_eq("a8_eject_seq", 32'(ej_code), 32'h210);
    check_eq("a8_eject_n", 32'(ej_n), 32'd3);
    check_eq("a8_remaining_seq", 32'(rem_code), 32'h8310);
    check_eq("a8_done_pulses", 32'(n_done), 32'd1);
    check_eq("a8_fault", 32'(fault), 32'd0);
    check_eq("a8_eject_cycles", 32'(ej_cycles), 32'd12);

    // 7 units with the 5-unit hopper empty: 2,2,2,1
    apply_reset();
    empty = 3'b100;
    start_req(8'd7);
    wait_end("a7_end", 300, k);
    @(negedge clk);
    check_eq("a7_eject_seq", 32'(ej_code), 32'h1110);
    check_eq("a7_eject_n", 32'(ej_n), 32'd4);
    check_eq("a7_remaining_seq", 32'(rem_code), 32'h75310);
    check_eq("a7_done_pulses", 32'(n_done), 32'd1);
    check_eq("a7_fault", 32'(fault), 32'd0);

    // 4 units, only the 5-unit hopper stocked: immediate fault
    apply_reset();
    empty = 3'b011;
    start_req(8'd4);
    wait_end("a4_end", 50, k);
    check_eq("a4_fault_latency", 32'(k), 32'd1);
    check_eq("a4_fault", 32'(fault), 32'd1);
    check_eq("a4_busy", 32'(busy), 32'd0);
    check_eq("a4_remaining", 32'(remaining), 32'd4);
    @(negedge clk);
    check_eq("a4_req_ready", 32'(req_ready), 32'd1);
    check_eq("a4_fault_held", 32'(fault), 32'd1);
    check_eq("a4_eject_n", 32'(ej_n), 32'd0);

    // Zero request right after the fault: clears fault, done at T+2
    empty = 3'b000;
    start_req(8'd0);
    check_eq("z_fault_cleared", 32'(fault), 32'd0);
    check_eq("z_busy", 32'(busy), 32'd1);
    check_eq("z_req_ready_low", 32'(req_ready), 32'd0);
    wait_end("z_end", 20, k);
    check_eq("z_done_latency", 32'(k), 32'd1);
    check_eq("z_done", 32'(done), 32'd1);
    check_eq("z_req_ready", 32'(req_ready), 32'd1);
    check_eq("z_eject", 32'(eject), 32'd0);
    @(negedge clk);
    check_eq("z_done_pulse", 32'(done), 32'd0);
    check_eq("z_eject_n", 32'(ej_n), 32'd0);

    // 5 units, sensor silent: timeout fault
    apply_reset();
    sensor_en = 1'b0;
    start_req(8'd5);
    wait_end("t_end", 100, k);
`ifdef CAMBIO_RETRY_EN
    check_eq("t_fault_latency", 32'(k), 32'd41);
    check_eq("t_eject_n", 32'(ej_n), 32'd2);
`else
    check_eq("t_fault_latency", 32'(k), 32'd21);
    check_eq("t_eject_n", 32'(ej_n), 32'd1);
`endif
    check_eq("t_fault", 32'(fault), 32'd1);
    check_eq("t_remaining", 32'(remaining), 32'd5);
    check_eq("t_busy", 32'(busy), 32'd0);

    // Reset during the 2nd cycle of an eject pulse
    apply_reset();
    sensor_en = 1'b1;
    start_req(8'd8);
    k = 0;
    while (eject == 0 && k < 10) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    #1;
    check_eq("r_eject_before", 32'(eject), 32'h4);
    rst = 1'b1;
    #1;
    check_eq("r_eject_async", 32'(eject), 32'd0);
    check_eq("r_busy_async", 32'(busy), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("r_req_ready", 32'(req_ready), 32'd1);
    check_eq("r_remaining", 32'(remaining), 32'd0);
    check_eq("r_fault", 32'(fault), 32'd0);
    check_eq("r_done", 32'(done), 32'd0);
    check_eq("r_busy", 32'(busy), 32'd0);
    repeat (5) @(negedge clk);
    check_eq("r_no_resume", 32'(eject), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
